// File: rtl/uart_frame_parser.sv
// Pops bytes from the UART RX FIFO, assembles SOF/LEN/CMD/payload/CHK frames and holds each good frame for the host.
// One byte per two cycles; bad, oversized or stalled frames are dropped with a single-cycle error pulse.
module uart_frame_parser #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    MAX_PAYLOAD    = 16,
    parameter logic [DATA_WIDTH-1:0] SOF            = 8'hA5,
    parameter int                    TIMEOUT_CYCLES = 500000,
    localparam int                   AW             = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RX_FIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0] RX_FIFO_DATA_OUT,
    output logic                  RX_FIFO_RD_EN,
    output logic                  FRAME_VALID,
    input  logic                  FRAME_ACK,
    output logic [DATA_WIDTH-1:0] FRAME_CMD,
    output logic [7:0]            FRAME_LEN,
    input  logic [AW-1:0]         PAYLOAD_ADDR,
    output logic [DATA_WIDTH-1:0] PAYLOAD_DATA,
    output logic                  CHECKSUM_ERROR,
    output logic                  LENGTH_ERROR,
    output logic                  TIMEOUT_ERROR,
    output logic                  BUSY
);

    localparam logic [2:0] S_HUNT    = 3'd0;
    localparam logic [2:0] S_LEN     = 3'd1;
    localparam logic [2:0] S_CMD     = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_CHK     = 3'd4;
    localparam logic [2:0] S_HOLD    = 3'd5;

    localparam logic [DATA_WIDTH-1:0] MAX_LEN = DATA_WIDTH'(MAX_PAYLOAD);
    localparam logic [31:0]           TMO_LIM = 32'(TIMEOUT_CYCLES);

    logic [2:0]            state_q, state_d;
    logic                  rd_pending_q, rd_pending_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            acc_q, acc_d;
    logic [7:0]            idx_q, idx_d;
    logic [DATA_WIDTH-1:0] cmd_q, cmd_d;
    logic [31:0]           tmo_q, tmo_d;
    logic                  chk_err_q, chk_err_d;
    logic                  len_err_q, len_err_d;
    logic                  tmo_err_q, tmo_err_d;
    logic [DATA_WIDTH-1:0] buf_q [MAX_PAYLOAD];
    logic [DATA_WIDTH-1:0] buf_d [MAX_PAYLOAD];

    logic                  fetch_state;
    logic                  counting;
    logic                  rd_en;
    logic                  tmo_hit;
    logic [DATA_WIDTH-1:0] rx_byte;
    logic [7:0]            acc_sum;

    assign rx_byte     = RX_FIFO_DATA_OUT;
    assign acc_sum     = acc_q + rx_byte[7:0];
    assign fetch_state = (state_q != S_HOLD);
    assign counting    = (state_q == S_LEN) || (state_q == S_CMD) ||
                         (state_q == S_PAYLOAD) || (state_q == S_CHK);
    // Gated by reset so no pop request escapes while the parser is held in reset.
    assign rd_en       = reset && fetch_state && !RX_FIFO_EMPTY && !rd_pending_q;
    // A byte already in flight is not a stall; the pulse rises on the TIMEOUT_CYCLES-th
    // edge after the last accepted byte, i.e. the edge the counter would reach the limit.
    assign tmo_hit     = (TMO_LIM != 32'd0) && counting && !rd_pending_q && !rd_en &&
                         (tmo_q == TMO_LIM - 32'd1);

    always_comb begin
        state_d      = state_q;
        rd_pending_d = rd_en;
        len_d        = len_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        cmd_d        = cmd_q;
        tmo_d        = (counting && TMO_LIM != 32'd0) ? tmo_q + 32'd1 : 32'd0;
        chk_err_d    = 1'b0;
        len_err_d    = 1'b0;
        tmo_err_d    = 1'b0;
        buf_d        = buf_q;

        if (rd_pending_q) begin
            tmo_d = 32'd0;
            case (state_q)
                S_HUNT: begin
                    if (rx_byte == SOF) begin
                        acc_d   = 8'd0;
                        state_d = S_LEN;
                    end
                end
                S_LEN: begin
                    if (rx_byte != '0 && rx_byte <= MAX_LEN) begin
                        len_d   = rx_byte[7:0];
                        acc_d   = acc_sum;
                        state_d = S_CMD;
                    end else begin
                        len_err_d = 1'b1;
                        state_d   = S_HUNT;
                    end
                end
                S_CMD: begin
                    cmd_d   = rx_byte;
                    acc_d   = acc_sum;
                    idx_d   = 8'd0;
                    state_d = S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    buf_d[idx_q[AW-1:0]] = rx_byte;
                    acc_d                = acc_sum;
                    idx_d                = idx_q + 8'd1;
                    if (idx_q == len_q - 8'd1) begin
                        state_d = S_CHK;
                    end
                end
                S_CHK: begin
                    if (acc_sum == 8'd0) begin
                        state_d = S_HOLD;
                    end else begin
                        chk_err_d = 1'b1;
                        state_d   = S_HUNT;
                    end
                end
                default: state_d = S_HUNT;
            endcase
        end else if (tmo_hit) begin
            tmo_err_d = 1'b1;
            tmo_d     = 32'd0;
            state_d   = S_HUNT;
        end else if (state_q == S_HOLD) begin
            if (FRAME_ACK) begin
                state_d = S_HUNT;
            end
        end else if (state_q > S_HOLD) begin
            state_d = S_HUNT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_HUNT;
            rd_pending_q <= 1'b0;
            len_q        <= 8'd0;
            acc_q        <= 8'd0;
            idx_q        <= 8'd0;
            cmd_q        <= '0;
            tmo_q        <= 32'd0;
            chk_err_q    <= 1'b0;
            len_err_q    <= 1'b0;
            tmo_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_pending_q <= rd_pending_d;
            len_q        <= len_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            cmd_q        <= cmd_d;
            tmo_q        <= tmo_d;
            chk_err_q    <= chk_err_d;
            len_err_q    <= len_err_d;
            tmo_err_q    <= tmo_err_d;
        end
    end

    // Payload storage carries no reset; its contents only matter while a frame is held.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign RX_FIFO_RD_EN  = rd_en;
    assign FRAME_VALID    = (state_q == S_HOLD);
    assign FRAME_CMD      = cmd_q;
    assign FRAME_LEN      = len_q;
    assign PAYLOAD_DATA   = buf_q[PAYLOAD_ADDR];
    assign CHECKSUM_ERROR = chk_err_q;
    assign LENGTH_ERROR   = len_err_q;
    assign TIMEOUT_ERROR  = tmo_err_q;
    assign BUSY           = (state_q != S_HUNT);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: a behavioural RX FIFO feeds hand-built frames, outputs are checked against hand-computed values.
module tb_uart_frame_parser;

    logic       clk;
    logic       reset;
    logic       RX_FIFO_EMPTY;
    logic [7:0] RX_FIFO_DATA_OUT;
    logic       RX_FIFO_RD_EN;
    logic       FRAME_VALID;
    logic       FRAME_ACK;
    logic [7:0] FRAME_CMD;
    logic [7:0] FRAME_LEN;
    logic [3:0] PAYLOAD_ADDR;
    logic [7:0] PAYLOAD_DATA;
    logic       CHECKSUM_ERROR;
    logic       LENGTH_ERROR;
    logic       TIMEOUT_ERROR;
    logic       BUSY;

    uart_frame_parser #(
        .DATA_WIDTH    (8),
        .MAX_PAYLOAD   (16),
        .SOF           (8'hA5),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .RX_FIFO_EMPTY   (RX_FIFO_EMPTY),
        .RX_FIFO_DATA_OUT(RX_FIFO_DATA_OUT),
        .RX_FIFO_RD_EN   (RX_FIFO_RD_EN),
        .FRAME_VALID     (FRAME_VALID),
        .FRAME_ACK       (FRAME_ACK),
        .FRAME_CMD       (FRAME_CMD),
        .FRAME_LEN       (FRAME_LEN),
        .PAYLOAD_ADDR    (PAYLOAD_ADDR),
        .PAYLOAD_DATA    (PAYLOAD_DATA),
        .CHECKSUM_ERROR  (CHECKSUM_ERROR),
        .LENGTH_ERROR    (LENGTH_ERROR),
        .TIMEOUT_ERROR   (TIMEOUT_ERROR),
        .BUSY            (BUSY)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] fifo_q[$];
    logic [7:0] frm[$];
    int         checks;
    int         errors;
    int         n;
    int         n_chk, n_len, n_tmo, n_rise;
    int         n_multi, n_wide, n_hold_rd, n_empty_rd;
    logic       prev_valid, prev_err, rd_s, any_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample the pop request before the edge, model the FIFO read just after
    // it, then tally the pulse outputs of the new cycle at the falling edge.
    task automatic step();
        #1;
        rd_s = RX_FIFO_RD_EN;
        if (rd_s && RX_FIFO_EMPTY) n_empty_rd++;
        if (rd_s && FRAME_VALID) n_hold_rd++;
        @(posedge clk);
        #1;
        if (rd_s && fifo_q.size() > 0) RX_FIFO_DATA_OUT = fifo_q.pop_front();
        RX_FIFO_EMPTY = (fifo_q.size() == 0);
        @(negedge clk);
        if (CHECKSUM_ERROR) n_chk++;
        if (LENGTH_ERROR) n_len++;
        if (TIMEOUT_ERROR) n_tmo++;
        if ((32'(CHECKSUM_ERROR) + 32'(LENGTH_ERROR) + 32'(TIMEOUT_ERROR)) > 1) n_multi++;
        any_err = CHECKSUM_ERROR | LENGTH_ERROR | TIMEOUT_ERROR;
        if (any_err && prev_err) n_wide++;
        if (FRAME_VALID && !prev_valid) begin
            n_rise++;
            if (any_err) n_multi++;
        end
        prev_err   = any_err;
        prev_valid = FRAME_VALID;
    endtask

    task automatic push_all(input logic [7:0] bs[$]);
        foreach (bs[i]) fifo_q.push_back(bs[i]);
        RX_FIFO_EMPTY = (fifo_q.size() == 0);
    endtask

    task automatic wait_valid(input int budget, output int cnt);
        cnt = 0;
        while (!FRAME_VALID && cnt < budget) begin
            step();
            cnt++;
        end
    endtask

    task automatic ack();
        FRAME_ACK = 1'b1;
        step();
        FRAME_ACK = 1'b0;
    endtask

    task automatic rd_pay(input string tag, input logic [3:0] a, input logic [7:0] exp);
        PAYLOAD_ADDR = a;
        #1;
        chk(tag, 32'(PAYLOAD_DATA), 32'(exp));
    endtask

    task automatic clr();
        n_chk  = 0;
        n_len  = 0;
        n_tmo  = 0;
        n_rise = 0;
    endtask

    initial begin
        checks = 0; errors = 0; n = 0;
        n_multi = 0; n_wide = 0; n_hold_rd = 0; n_empty_rd = 0;
        prev_valid = 1'b0; prev_err = 1'b0; rd_s = 1'b0; any_err = 1'b0;
        clr();
        reset = 1'b0;
        FRAME_ACK = 1'b0;
        PAYLOAD_ADDR = 4'd0;
        RX_FIFO_EMPTY = 1'b1;
        RX_FIFO_DATA_OUT = 8'h00;

        // Reset state, with a byte waiting so a leaked pop would show.
        frm = '{8'h00};
        push_all(frm);
        repeat (2) @(negedge clk);
        chk("rst_rd_en", 32'(RX_FIFO_RD_EN), 0);
        chk("rst_valid", 32'(FRAME_VALID), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_err", 32'({CHECKSUM_ERROR, LENGTH_ERROR, TIMEOUT_ERROR}), 0);
        chk("rst_cmd", 32'(FRAME_CMD), 0);
        chk("rst_len", 32'(FRAME_LEN), 0);
        reset = 1'b1;
        repeat (2) step();
        chk("drain_busy", 32'(BUSY), 0);

        // Good frame: 03+10+11+22+33 = 79h, so the checksum is 100h-79h = 87h.
        clr();
        frm = '{8'hA5, 8'h03, 8'h10, 8'h11, 8'h22, 8'h33, 8'h87};
        push_all(frm);
        wait_valid(40, n);
        chk("f1_latency", n, 14);
        chk("f1_cmd", 32'(FRAME_CMD), 'h10);
        chk("f1_len", 32'(FRAME_LEN), 3);
        rd_pay("f1_p0", 4'd0, 8'h11);
        rd_pay("f1_p1", 4'd1, 8'h22);
        rd_pay("f1_p2", 4'd2, 8'h33);
        chk("f1_no_err", n_chk + n_len + n_tmo, 0);
        ack();
        chk("f1_ack_valid", 32'(FRAME_VALID), 0);
        chk("f1_ack_busy", 32'(BUSY), 0);

        // Garbage ahead of SOF is discarded at the normal byte rate.
        clr();
        frm = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h20, 8'h01, 8'h02, 8'hDB};
        push_all(frm);
        wait_valid(60, n);
        chk("f2_latency", n, 18);
        chk("f2_cmd", 32'(FRAME_CMD), 'h20);
        chk("f2_len", 32'(FRAME_LEN), 2);
        rd_pay("f2_p0", 4'd0, 8'h01);
        rd_pay("f2_p1", 4'd1, 8'h02);
        chk("f2_no_err", n_chk + n_len + n_tmo, 0);
        ack();

        // Bad checksum, then a good frame straight behind it.
        clr();
        frm = '{8'hA5, 8'h03, 8'h10, 8'h11, 8'h22, 8'h33, 8'h98,
                8'hA5, 8'h02, 8'h20, 8'h01, 8'h02, 8'hDB};
        push_all(frm);
        wait_valid(80, n);
        chk("f3_latency", n, 26);
        chk("f3_chk_pulses", n_chk, 1);
        chk("f3_other_err", n_len + n_tmo, 0);
        chk("f3_rise", n_rise, 1);
        chk("f3_cmd", 32'(FRAME_CMD), 'h20);
        ack();

        // LEN=0 and LEN=17 rejected; stray 10h hunted away; then a 1-byte frame.
        clr();
        frm = '{8'hA5, 8'h00, 8'hA5, 8'h11, 8'h10, 8'hA5, 8'h01, 8'h30, 8'h44, 8'h8B};
        push_all(frm);
        wait_valid(60, n);
        chk("f4_latency", n, 20);
        chk("f4_len_pulses", n_len, 2);
        chk("f4_other_err", n_chk + n_tmo, 0);
        chk("f4_cmd", 32'(FRAME_CMD), 'h30);
        chk("f4_len", 32'(FRAME_LEN), 1);
        rd_pay("f4_p0", 4'd0, 8'h44);
        ack();

        // LEN = MAX_PAYLOAD: 10h+40h+(0..15 = 78h) = C8h, checksum 38h.
        clr();
        frm = '{8'hA5, 8'h10, 8'h40};
        for (int i = 0; i < 16; i++) frm.push_back(8'(i));
        frm.push_back(8'h38);
        push_all(frm);
        wait_valid(80, n);
        chk("f5_latency", n, 40);
        chk("f5_len", 32'(FRAME_LEN), 16);
        rd_pay("f5_p0", 4'd0, 8'h00);
        rd_pay("f5_p7", 4'd7, 8'h07);
        rd_pay("f5_p15", 4'd15, 8'h0F);
        chk("f5_no_err", n_chk + n_len + n_tmo, 0);
        ack();

        // Stall after CMD: the 10h byte is sampled in cycle 5, the pulse lands in cycle 106.
        clr();
        frm = '{8'hA5, 8'h03, 8'h10};
        push_all(frm);
        for (int i = 0; i < 105; i++) step();
        chk("tmo_before", 32'(TIMEOUT_ERROR), 0);
        chk("tmo_busy_before", 32'(BUSY), 1);
        step();
        chk("tmo_pulse", 32'(TIMEOUT_ERROR), 1);
        chk("tmo_busy", 32'(BUSY), 0);
        step();
        chk("tmo_after", 32'(TIMEOUT_ERROR), 0);
        chk("tmo_count", n_tmo, 1);

        // Reset mid-payload aborts at once, silently, and leaves the FIFO alone.
        clr();
        frm = '{8'hA5, 8'h03, 8'h10, 8'h11};
        push_all(frm);
        repeat (8) step();
        chk("mid_busy", 32'(BUSY), 1);
        frm = '{8'h22};
        push_all(frm);
        reset = 1'b0;
        #1;
        chk("mid_rst_rd_en", 32'(RX_FIFO_RD_EN), 0);
        chk("mid_rst_busy", 32'(BUSY), 0);
        chk("mid_rst_cmd", 32'(FRAME_CMD), 0);
        chk("mid_rst_len", 32'(FRAME_LEN), 0);
        chk("mid_rst_valid", 32'(FRAME_VALID), 0);
        step();
        chk("mid_rst_fifo", fifo_q.size(), 1);
        reset = 1'b1;
        repeat (2) step();
        chk("mid_rst_no_err", n_chk + n_len + n_tmo, 0);
        chk("mid_rst_idle", 32'(BUSY), 0);

        // Two queued frames with a slow ACK: nothing is popped while the first is held.
        // 01+50+66 = B7h -> 49h; 02+60+77+88 = 161h -> 61h -> 9Fh.
        clr();
        frm = '{8'hA5, 8'h01, 8'h50, 8'h66, 8'h49, 8'hA5, 8'h02, 8'h60, 8'h77, 8'h88, 8'h9F};
        push_all(frm);
        wait_valid(40, n);
        chk("b2b_latency1", n, 10);
        repeat (50) step();
        chk("b2b_hold_valid", 32'(FRAME_VALID), 1);
        chk("b2b_hold_cmd", 32'(FRAME_CMD), 'h50);
        chk("b2b_hold_len", 32'(FRAME_LEN), 1);
        rd_pay("b2b_hold_p0", 4'd0, 8'h66);
        chk("b2b_hold_rd", n_hold_rd, 0);
        chk("b2b_fifo_left", fifo_q.size(), 6);
        ack();
        chk("b2b_ack_valid", 32'(FRAME_VALID), 0);
        chk("b2b_ack_rd_en", 32'(RX_FIFO_RD_EN), 1);
        wait_valid(40, n);
        chk("b2b_latency2", n, 12);
        chk("b2b_cmd2", 32'(FRAME_CMD), 'h60);
        chk("b2b_len2", 32'(FRAME_LEN), 2);
        rd_pay("b2b_p0", 4'd0, 8'h77);
        rd_pay("b2b_p1", 4'd1, 8'h88);
        ack();
        chk("b2b_rise", n_rise, 2);
        chk("b2b_no_err", n_chk + n_len + n_tmo, 0);

        chk("rd_when_empty", n_empty_rd, 0);
        chk("pulse_overlap", n_multi, 0);
        chk("pulse_width", n_wide, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
